// File: rtl/dmem_waitstate.sv
// dmem_waitstate: word-organised data memory behind a req/ready/done handshake.
// An accepted request is held for WAIT_CYCLES extra cycles and then completed
// with a one-cycle done pulse. Writes honour byte-lane enables. Any access
// whose word index falls outside the array reports err and has no effect.
// Optional build macro DMEM_ALIGN_CHECK_EN: when it is defined, an access with
// nonzero byte-offset bits is also reported as an error.
module dmem_waitstate #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic                done,
  output logic [DATA_W-1:0]   rd_data,
  output logic                err
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              state, state_nx;
  logic [3:0]          cnt;
  logic                we_q, bad_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   wd_q;
  logic [NB-1:0]       be_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept, bad_in, enter_done;
  logic                ac_we, ac_bad;
  logic [IDX_W-1:0]    idx_in, ac_idx;

  assign ready  = rst && (state == S_IDLE);
  assign accept = req && ready;
  assign done   = (state == S_DONE);
  assign err    = done && bad_q;

  // The range check looks at every address bit above the index field, so an
  // out-of-range address never aliases onto a real word.
  assign idx_in = addr[OFF_W +: IDX_W];
`ifdef DMEM_ALIGN_CHECK_EN
  assign bad_in = ((addr >> (OFF_W + IDX_W)) != '0) ||
                  ((addr & ADDR_W'(NB - 1)) != '0);
`else
  assign bad_in = ((addr >> (OFF_W + IDX_W)) != '0);
`endif

  // With zero wait states DONE is entered on the accept edge itself, before
  // the request has been captured, so the read path takes the live inputs then.
  assign ac_we      = (state == S_IDLE) ? we     : we_q;
  assign ac_bad     = (state == S_IDLE) ? bad_in : bad_q;
  assign ac_idx     = (state == S_IDLE) ? idx_in : idx_q;
  assign enter_done = (state_nx == S_DONE) && (state != S_DONE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next-state logic: IDLE -> [WAIT x WAIT_CYCLES] -> DONE (one cycle) -> IDLE
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
      S_WAIT: if (cnt == 4'd1) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Wait-state counter: loaded on accept and counted down to 1 in WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt <= '0;
    else if (accept)           cnt <= 4'(WAIT_CYCLES);
    else if (state == S_WAIT)  cnt <= cnt - 4'd1;
  end

  // Request capture at accept; later input changes are ignored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q  <= 1'b0;
      bad_q <= 1'b0;
      idx_q <= '0;
      wd_q  <= '0;
      be_q  <= '0;
    end else if (accept) begin
      we_q  <= we;
      bad_q <= bad_in;
      idx_q <= idx_in;
      wd_q  <= wr_data;
      be_q  <= be;
    end
  end

  // Read data is loaded on entry to DONE and held until the next read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      rd_data <= '0;
    else if (enter_done && !ac_we) rd_data <= ac_bad ? '0 : mem[ac_idx];
  end

  // Write commit on the edge leaving DONE; reset forces IDLE so an aborted
  // access never reaches this point. The array itself is never cleared.
  always_ff @(posedge clk) begin
    if (state == S_DONE && we_q && !bad_q) begin
      for (int i = 0; i < NB; i++)
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wd_q[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_dmem_waitstate.sv
// tb_dmem_waitstate: randomized accesses against a word-array reference model.
module tb_dmem_waitstate;
  localparam int DW = 32, AW = 32, DEPTH = 64, WC = 2;

  logic          clk = 1'b0, rst = 1'b0;
  logic          req = 1'b0, we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [3:0]    be = '0;
  logic          ready, done, err;
  logic [DW-1:0] rd_data;

  dmem_waitstate #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wr_data(wr_data),
    .be(be), .ready(ready), .done(done), .rd_data(rd_data), .err(err));

  always #5 clk = ~clk;

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] last_rd;
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit is_bad(input logic [AW-1:0] a);
    bit b;
    b = (a >= 32'(DEPTH * 4));
`ifdef DMEM_ALIGN_CHECK_EN
    if (a % 4 != 0) b = 1'b1;
`endif
    return b;
  endfunction

  // One full transaction: wait for ready, issue, check timing and results.
  task automatic access(input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] b);
    int k;
    bit bad;
    logic [DW-1:0] exp_rd;
    k = 0;
    @(negedge clk);
    while (!ready && k < 20) begin @(negedge clk); k++; end
    if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
    req = 1'b1; we = w; addr = a; wr_data = d; be = b;
    @(posedge clk);
    #1;
    // Scramble inputs: the block must use only what it captured at accept.
    req = 1'b0; we = $urandom; addr = $urandom; wr_data = $urandom; be = $urandom;
    bad = is_bad(a);
    exp_rd = last_rd;
    if (!w) exp_rd = bad ? '0 : model[a / 4 % DEPTH];
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (!done) chk("ready_busy", 32'(ready), 32'd0);
    end while (!done && k < 20);
    chk("latency", k, 32'(WC + 1));
    chk("ready_done", 32'(ready), 32'd0);
    chk("err", 32'(err), 32'(bad));
    chk(w ? "rd_hold" : "rd_data", rd_data, exp_rd);
    last_rd = exp_rd;
    if (w && !bad)
      for (int i = 0; i < 4; i++)
        if (b[i]) model[a / 4][8*i +: 8] = d[8*i +: 8];
  endtask

  initial begin
    logic [AW-1:0] a;
    int r, last;

    // Reset state
    #12;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    @(negedge clk); rst = 1'b1;
    last_rd = '0;

    // Give every word a known value
    for (int i = 0; i < DEPTH; i++) access(1'b1, 32'(i * 4), $urandom, 4'hF);

    // Full write then read back
    access(1'b1, 32'h10, 32'h12345678, 4'hF);
    access(1'b0, 32'h10, 32'h0, 4'h0);
    // Byte lanes
    access(1'b1, 32'h4, 32'hAABBCCDD, 4'hF);
    access(1'b1, 32'h4, 32'h11223344, 4'b0101);
    access(1'b0, 32'h4, 32'h0, 4'h0);
    chk("lanes", rd_data, 32'hAA22CC44);
    // be = 0 leaves the word alone
    access(1'b1, 32'h4, 32'h55555555, 4'h0);
    access(1'b0, 32'h4, 32'h0, 4'h0);
    // Out of range: no aliasing onto word 0
    access(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF);
    access(1'b0, 32'h0, 32'h0, 4'h0);
    access(1'b0, 32'h100, 32'h0, 4'h0);
    access(1'b0, 32'h8000_0000, 32'h0, 4'h0);
    // Misaligned read
    access(1'b0, 32'h6, 32'h0, 4'h0);

    // Reset in the middle of a write's WAIT phase
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h8; wr_data = 32'hDEADBEEF; be = 4'hF;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_rd", rd_data, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_err", 32'(err), 32'd0);
    end
    rst = 1'b1;
    last_rd = '0;
    access(1'b0, 32'h8, 32'h0, 4'h0);

    // req held high: one accept per WC+2 cycles
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10; be = 4'h0;
    last = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (done) begin
        if (last >= 0) chk("b2b_gap", 32'(c - last), 32'(WC + 2));
        chk("b2b_rd", rd_data, model[4]);
        last = c;
      end
    end
    req = 1'b0;
    r = 0;
    while (!ready && r < 20) begin @(negedge clk); r++; end
    chk("b2b_idle", 32'(ready), 32'd1);
    last_rd = model[4];

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom | 32'h100;
      else if (r == 1) a = 32'($urandom_range(0, DEPTH * 4 - 1));
      else             a = 32'($urandom_range(0, DEPTH - 1) * 4);
      access(1'($urandom), a, $urandom, 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
